// File: rtl/rs_constants_pkg.sv
// Shared reservation-station packet layout, FU indices and execute-stage encodings.
// Field positions are given as LSB offsets into the flat RS_WIDTH-bit packet.
package rs_constants_pkg;

    localparam int RS_ROB_LO  = 0;
    localparam int RS_ROB_W   = 6;
    localparam int RS_RD_LO   = 6;
    localparam int RS_RD_W    = 8;
    localparam int RS_FU_LO   = 14;
    localparam int RS_FU_W    = 2;
    localparam int RS_OPC_LO  = 16;
    localparam int RS_OPC_W   = 7;
    localparam int RS_CSIG_LO = 23;
    localparam int RS_CSIG_W  = 4;
    localparam int RS_IMM_LO  = 27;
    localparam int RS_D2_LO   = 59;
    localparam int RS_D1_LO   = 91;
    localparam int RS_WIDTH   = 123;

    localparam int CSIG_ALUSRC = 3;
    localparam int NUM_FU      = 3;

    localparam logic [1:0] FU_ALU0 = 2'd0;
    localparam logic [1:0] FU_ALU1 = 2'd1;
    localparam logic [1:0] FU_LSU  = 2'd2;

    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic [31:0]           data1;
        logic [31:0]           data2;
        logic [31:0]           imm;
        logic [RS_CSIG_W-1:0]  csig;
        logic [RS_OPC_W-1:0]   opcode;
        logic [RS_FU_W-1:0]    fu;
        logic [RS_RD_W-1:0]    rd;
        logic [RS_ROB_W-1:0]   rob;
    } rs_pkt_t;

    function automatic rs_pkt_t unpackPkt(input logic [RS_WIDTH-1:0] raw);
        rs_pkt_t p;
        p.rob    = raw[RS_ROB_LO  +: RS_ROB_W];
        p.rd     = raw[RS_RD_LO   +: RS_RD_W];
        p.fu     = raw[RS_FU_LO   +: RS_FU_W];
        p.opcode = raw[RS_OPC_LO  +: RS_OPC_W];
        p.csig   = raw[RS_CSIG_LO +: RS_CSIG_W];
        p.imm    = raw[RS_IMM_LO  +: 32];
        p.data2  = raw[RS_D2_LO   +: 32];
        p.data1  = raw[RS_D1_LO   +: 32];
        return p;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Single-cycle ALU: result, destination tag and ROB number registered on the issue edge.
// Outputs hold their last values between issues.
module exec_alu
    import rs_constants_pkg::*;
#(
    parameter int PREG_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_issue,
    input  rs_pkt_t               i_pkt,
    output logic                  o_vld,
    output logic [PREG_WIDTH-1:0] o_rd,
    output logic [5:0]            o_rob,
    output logic [31:0]           o_data
);

    logic [31:0] w_opB;
    logic [31:0] w_result;
    logic        w_unused;

    assign w_opB    = i_pkt.csig[CSIG_ALUSRC] ? i_pkt.imm : i_pkt.data2;
    assign w_unused = ^{i_pkt.opcode, i_pkt.fu, i_pkt.rd};

    always_comb begin
        w_result = 32'd0;
        case (alu_op_e'(i_pkt.csig[2:0]))
            ALU_ADD: w_result = i_pkt.data1 + w_opB;
            ALU_SUB: w_result = i_pkt.data1 - w_opB;
            ALU_AND: w_result = i_pkt.data1 & w_opB;
            ALU_OR:  w_result = i_pkt.data1 | w_opB;
            ALU_XOR: w_result = i_pkt.data1 ^ w_opB;
            ALU_SLL: w_result = i_pkt.data1 << w_opB[4:0];
            ALU_SRL: w_result = i_pkt.data1 >> w_opB[4:0];
            ALU_SLT: w_result = {31'd0, $signed(i_pkt.data1) < $signed(w_opB)};
            default: w_result = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_vld  <= 1'b0;
            o_rd   <= '0;
            o_rob  <= '0;
            o_data <= '0;
        end else begin
            o_vld <= i_issue;
            if (i_issue) begin
                o_rd   <= i_pkt.rd[PREG_WIDTH-1:0];
                o_rob  <= i_pkt.rob;
                o_data <= w_result;
            end
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: routes issued RS packets to two pipelined ALUs and a blocking LSU,
// flagging conflicting or busy-FU issues on a sticky error bit.
module exec_stage
    import rs_constants_pkg::*;
#(
    parameter int PREG_WIDTH = 6,
    parameter int MEM_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RS_WIDTH-1:0]   iss_pkt0,
    input  logic [RS_WIDTH-1:0]   iss_pkt1,
    input  logic [RS_WIDTH-1:0]   iss_pkt2,
    input  logic [2:0]            iss_vld,
    output logic [2:0]            fu_ready,
    output logic [2:0]            cmp_vld,
    output logic [PREG_WIDTH-1:0] cmp_rd0,
    output logic [PREG_WIDTH-1:0] cmp_rd1,
    output logic [PREG_WIDTH-1:0] cmp_rd2,
    output logic [31:0]           cmp_data0,
    output logic [31:0]           cmp_data1,
    output logic [31:0]           cmp_data2,
    output logic [5:0]            cmp_rob0,
    output logic [5:0]            cmp_rob1,
    output logic [5:0]            cmp_rob2,
    output logic                  dmem_en,
    output logic                  dmem_we,
    output logic [31:0]           dmem_addr,
    output logic [31:0]           dmem_wdata,
    input  logic [31:0]           dmem_rdata,
    output logic                  iss_err
);

    rs_pkt_t               w_pkt [NUM_FU];
    logic [NUM_FU-1:0]     w_claim;
    logic [1:0]            w_sel [NUM_FU];
    logic                  w_drop;
    rs_pkt_t               w_alu0Pkt;
    rs_pkt_t               w_alu1Pkt;
    rs_pkt_t               w_lsuPkt;
    logic                  w_alu0Vld;
    logic                  w_alu1Vld;
    logic                  w_lsuDone;
    logic [31:0]           w_lsuData;
    logic                  w_unused;

    lsu_state_e            r_state;
    logic [2:0]            r_cnt;
    logic                  r_lsuStore;
    logic [PREG_WIDTH-1:0] r_lsuRd;
    logic [5:0]            r_lsuRob;
    logic [PREG_WIDTH-1:0] r_cmpRd2;
    logic [5:0]            r_cmpRob2;
    logic [31:0]           r_cmpData2;
    logic                  r_issErr;

    assign w_pkt[0] = unpackPkt(iss_pkt0);
    assign w_pkt[1] = unpackPkt(iss_pkt1);
    assign w_pkt[2] = unpackPkt(iss_pkt2);

    assign fu_ready = {r_state == LSU_IDLE, 2'b11};

    // Slots are scanned in index order, so the lowest slot claims an FU first.
    always_comb begin
        w_claim = '0;
        w_drop  = 1'b0;
        for (int f = 0; f < NUM_FU; f++) begin
            w_sel[f] = 2'd0;
        end
        for (int k = 0; k < NUM_FU; k++) begin
            if (iss_vld[k] && (int'(w_pkt[k].fu) < NUM_FU)) begin
                if (w_claim[w_pkt[k].fu] || !fu_ready[w_pkt[k].fu]) begin
                    w_drop = 1'b1;
                end else begin
                    w_claim[w_pkt[k].fu] = 1'b1;
                    w_sel[w_pkt[k].fu]   = 2'(k);
                end
            end
        end
    end

    assign w_alu0Pkt = w_pkt[w_sel[FU_ALU0]];
    assign w_alu1Pkt = w_pkt[w_sel[FU_ALU1]];
    assign w_lsuPkt  = w_pkt[w_sel[FU_LSU]];
    assign w_unused  = ^{w_lsuPkt.csig, w_lsuPkt.fu, w_lsuPkt.rd};

    exec_alu #(.PREG_WIDTH(PREG_WIDTH)) u_alu0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_issue (w_claim[FU_ALU0]),
        .i_pkt   (w_alu0Pkt),
        .o_vld   (w_alu0Vld),
        .o_rd    (cmp_rd0),
        .o_rob   (cmp_rob0),
        .o_data  (cmp_data0)
    );

    exec_alu #(.PREG_WIDTH(PREG_WIDTH)) u_alu1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_issue (w_claim[FU_ALU1]),
        .i_pkt   (w_alu1Pkt),
        .o_vld   (w_alu1Vld),
        .o_rd    (cmp_rd1),
        .o_rob   (cmp_rob1),
        .o_data  (cmp_data1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issErr <= 1'b0;
        end else if (w_drop) begin
            r_issErr <= 1'b1;
        end
    end

    assign iss_err = r_issErr;

    // Load data is only valid during DONE, so completion data is passed through
    // combinationally then and held in r_cmp* afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LSU_IDLE;
            r_cnt      <= 3'd0;
            dmem_en    <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            r_lsuStore <= 1'b0;
            r_lsuRd    <= '0;
            r_lsuRob   <= '0;
            r_cmpRd2   <= '0;
            r_cmpRob2  <= '0;
            r_cmpData2 <= '0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_claim[FU_LSU]) begin
                        r_state    <= LSU_REQ;
                        dmem_en    <= 1'b1;
                        dmem_we    <= (w_lsuPkt.opcode == OPC_STORE);
                        dmem_addr  <= w_lsuPkt.data1 + w_lsuPkt.imm;
                        dmem_wdata <= w_lsuPkt.data2;
                        r_lsuStore <= (w_lsuPkt.opcode == OPC_STORE);
                        r_lsuRd    <= w_lsuPkt.rd[PREG_WIDTH-1:0];
                        r_lsuRob   <= w_lsuPkt.rob;
                    end
                end
                LSU_REQ: begin
                    dmem_en <= 1'b0;
                    dmem_we <= 1'b0;
                    if (MEM_LAT == 1) begin
                        r_state <= LSU_DONE;
                    end else begin
                        r_cnt   <= 3'(MEM_LAT - 1);
                        r_state <= LSU_WAIT;
                    end
                end
                LSU_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    r_state    <= LSU_IDLE;
                    r_cmpData2 <= w_lsuData;
                    r_cmpRd2   <= r_lsuRd;
                    r_cmpRob2  <= r_lsuRob;
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    assign w_lsuDone = (r_state == LSU_DONE);
    assign w_lsuData = r_lsuStore ? 32'd0 : dmem_rdata;

    assign cmp_vld   = {w_lsuDone, w_alu1Vld, w_alu0Vld};
    assign cmp_data2 = w_lsuDone ? w_lsuData : r_cmpData2;
    assign cmp_rd2   = w_lsuDone ? r_lsuRd   : r_cmpRd2;
    assign cmp_rob2  = w_lsuDone ? r_lsuRob  : r_cmpRob2;

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter PREG_WIDTH, default 6, physical register tag width.
REQ-002 Parameter MEM_LAT, default 2, LSU memory latency in cycles (legal range 1..7).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 iss_pkt0/iss_pkt1/iss_pkt2  input  RS_WIDTH each  issued reservation-station entries, in RS field layout.
REQ-006 iss_vld  input  3  bit k qualifies iss_pktk.
REQ-007 fu_ready  output  3  per-FU free bit (0=ALU0, 1=ALU1, 2=LSU), returned to the reservation station.
REQ-008 cmp_vld  output  3  per-FU completion strobe.
REQ-009 cmp_rd0..2  output  PREG_WIDTH each  destination tag of the completing instruction.
REQ-010 cmp_data0..2  output  32 each  result value.
REQ-011 cmp_rob0..2  output  6 each  ROB number of the completing instruction.
REQ-012 dmem_en, dmem_we  output  1 each  data-memory request and write enable.
REQ-013 dmem_addr, dmem_wdata  output  32 each  memory address and store data.
REQ-014 dmem_rdata  input  32  load data, valid exactly MEM_LAT cycles after the dmem_en cycle.
REQ-015 iss_err  output  1  sticky: two valid packets targeted the same FU, or a packet targeted a busy FU.

Function
REQ-016 Each valid packet SHALL be routed to the FU named by its RS_FU field, independent of slot index.
REQ-017 ALU0/ALU1: operands latched on the issue edge; the result SHALL appear on cmp_* with cmp_vld high in the following cycle (latency 1).
REQ-018 ALU operation SHALL be selected by RS_CSIG ALUOP subfield: ADD, SUB, AND, OR, XOR, SLL, SRL, SLT; second operand = imm when the ALUSRC c_sig bit is set, else data2; 32-bit wrap-around arithmetic, shift amount = operand[4:0].
REQ-019 An ALU is fully pipelined: fu_ready[0]/[1] SHALL stay 1 outside reset, and back-to-back issue every cycle is legal.
REQ-020 The LSU FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-021 IDLE->REQ on a valid LSU packet; REQ drives dmem_en=1 for one cycle with dmem_addr = data1 + imm, dmem_we = 1 for opcode 0100011, dmem_wdata = data2.
REQ-022 REQ->WAIT, with a 3-bit counter loaded to MEM_LAT-1; if MEM_LAT=1, REQ->DONE directly.
REQ-023 WAIT decrements each cycle and moves to DONE when the counter reaches 0.
REQ-024 DONE pulses cmp_vld[2] for one cycle (cmp_data2 = dmem_rdata for loads, 0 for stores; stores still complete) and then returns to IDLE.
REQ-025 fu_ready[2] SHALL be 0 from the cycle after LSU issue through the DONE cycle, and 1 in IDLE.
REQ-026 A packet whose FU is busy, or a second valid packet to an already-claimed FU in the same cycle, SHALL be dropped (lowest slot index wins) and SHALL set iss_err.
REQ-027 When cmp_vld[k]=0, cmp_rd/cmp_data/cmp_rob for FU k SHALL hold their last values.

Reset
REQ-028 While rst_n=0: cmp_vld=0, dmem_en=0, dmem_we=0, iss_err=0, fu_ready=3'b111, LSU FSM=IDLE, counter=0, and all cmp_* and dmem_* data buses = 0.
REQ-029 Reset asserted mid-LSU-operation SHALL abandon the operation with no completion; the first cycle after deassertion accepts new issues.

Structure
REQ-030 RS_WIDTH, the RS field position macros, FU index constants, ALUOP encodings and LSU state encodings SHALL reside in the shared rs_constants package/include.
REQ-031 ALU datapath SHALL be a single sub-module, exec_alu, instantiated twice; the LSU FSM stays in exec_stage.

Verification
REQ-032 ALU0 issue ADD, data1=5, data2=7, rd=12, rob=3 -> next cycle cmp_vld[0]=1, cmp_data0=12, cmp_rd0=12, cmp_rob0=3.
REQ-033 Slot0 packet targets ALU1 (SUB, 0-1) and slot1 packet targets ALU0 (XOR, F0F0 ^ FFFF) in the same cycle -> cmp_data1=32'hFFFFFFFF, cmp_data0=32'h0F0F.
REQ-034 Load with MEM_LAT=2, data1=0x100, imm=4, memory returns 0xDEAD -> dmem_addr=0x104 for one cycle, fu_ready[2]=0 for 3 cycles, cmp_data2=0xDEAD.
REQ-035 Second LSU packet issued while the LSU is busy -> dropped, iss_err=1, first load still completes correctly.
REQ-036 rst_n pulsed low during WAIT -> no cmp_vld[2], fu_ready=3'b111; a subsequent store completes with cmp_vld[2]=1 and cmp_data2=0.
